control_acceso_param: RTL and testbench

CONTROL_ACCESO_PARAM -- requirements
Module: control_acceso_param

---
 rtl/control_acceso_param.sv | 143 ++++++++++++++
 tb/tb_control_acceso_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/control_acceso_param.sv
// Parking-gate access controller: the vehicle arrives, a PIN is checked against a reprogrammable key,
// and the gate opens for a bounded time. Wrong PINs and tailgating lock the gate until an operator releases it.
module control_acceso_param #(
    parameter int                PIN_W        = 16,
    parameter logic [PIN_W-1:0]  CLAVE_INIT   = 16'h1194,
    parameter int                MAX_INTENTOS = 3,
    parameter int                T_ABIERTO    = 1000,
    localparam int               IW           = $clog2(MAX_INTENTOS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             llegado_vehiculo,
    input  logic             paso_vehiculo,
    input  logic             boton_reset,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] clave_ingresada,
    input  logic             cargar_clave,
    input  logic [PIN_W-1:0] clave_nueva,
    output logic             abriendo_compuerta,
    output logic             cerrando_compuerta,
    output logic             alarm_pin_incorrecto,
    output logic             alarm_timeout,
    output logic             alarm_bloqueo,
    output logic [IW-1:0]    intentos,
    output logic [1:0]       estado
);

    localparam int TW = (T_ABIERTO > 1) ? $clog2(T_ABIERTO) : 1;
    localparam logic [TW-1:0] TIMER_LAST   = TW'(T_ABIERTO - 1);
    localparam logic [IW-1:0] INTENTOS_MAX = IW'(MAX_INTENTOS);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ESPERA_CLAVE = 2'd1,
        ABIERTO      = 2'd2,
        BLOQUEO      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      intentos_q, intentos_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [PIN_W-1:0]   clave_q, clave_d;
    logic               abrir_d, cerrar_d, pin_mal_d, timeout_d;
    logic [IW-1:0]      intentos_inc;

    assign intentos_inc = intentos_q + IW'(1);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        intentos_d = intentos_q;
        timer_d    = timer_q;
        clave_d    = clave_q;
        abrir_d    = 1'b0;
        cerrar_d   = 1'b0;
        pin_mal_d  = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The key loads alongside an arrival, so the new key is in place before any PIN is checked.
                if (cargar_clave) begin
                    clave_d = clave_nueva;
                end
                if (llegado_vehiculo) begin
                    state_d    = ESPERA_CLAVE;
                    intentos_d = '0;
                end
            end

            ESPERA_CLAVE: begin
                if (pin_valid) begin
                    if (clave_ingresada == clave_q) begin
                        state_d    = ABIERTO;
                        intentos_d = '0;
                        timer_d    = '0;
                        abrir_d    = 1'b1;
                    end else begin
                        intentos_d = intentos_inc;
                        pin_mal_d  = 1'b1;
                        if (intentos_inc == INTENTOS_MAX) begin
                            state_d = BLOQUEO;
                        end
                    end
                end
            end

            ABIERTO: begin
                // A passage wins over a timeout in the same cycle; tailgating locks the gate without closing it.
                if (paso_vehiculo && llegado_vehiculo) begin
                    state_d = BLOQUEO;
                end else if (paso_vehiculo) begin
                    state_d  = IDLE;
                    cerrar_d = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = IDLE;
                    cerrar_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            BLOQUEO: begin
                if (boton_reset) begin
                    state_d    = IDLE;
                    intentos_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q              <= IDLE;
            intentos_q           <= '0;
            timer_q              <= '0;
            clave_q              <= CLAVE_INIT;
            abriendo_compuerta   <= 1'b0;
            cerrando_compuerta   <= 1'b0;
            alarm_pin_incorrecto <= 1'b0;
            alarm_timeout        <= 1'b0;
            alarm_bloqueo        <= 1'b0;
        end else begin
            state_q              <= state_d;
            intentos_q           <= intentos_d;
            timer_q              <= timer_d;
            clave_q              <= clave_d;
            abriendo_compuerta   <= abrir_d;
            cerrando_compuerta   <= cerrar_d;
            alarm_pin_incorrecto <= pin_mal_d;
            alarm_timeout        <= timeout_d;
            alarm_bloqueo        <= (state_d == BLOQUEO);
        end
    end

    assign estado   = state_q;
    assign intentos = intentos_q;

endmodule

// File: tb/tb_control_acceso_param.sv
// Bench for control_acceso_param: directed scenarios followed by random traffic, with every cycle
// compared against a rule-level model of the gate controller.
module tb_control_acceso_param;

    localparam int          PIN_W = 16;
    localparam logic [15:0] CLAVE = 16'h1194;
    localparam int          MAXI  = 3;
    localparam int          TOPEN = 8;
    localparam int          IW    = $clog2(MAXI + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             llegado_vehiculo, paso_vehiculo, boton_reset;
    logic             pin_valid, cargar_clave;
    logic [PIN_W-1:0] clave_ingresada, clave_nueva;
    logic             abriendo_compuerta, cerrando_compuerta;
    logic             alarm_pin_incorrecto, alarm_timeout, alarm_bloqueo;
    logic [IW-1:0]    intentos;
    logic [1:0]       estado;

    int checks = 0;
    int errors = 0;

    // Reference model: gate phase as an int (0 idle, 1 waiting PIN, 2 open, 3 locked).
    int          m_state, m_att, m_timer;
    logic [15:0] m_key;
    bit          e_abr, e_cer, e_inc, e_to;

    control_acceso_param #(
        .PIN_W(PIN_W), .CLAVE_INIT(CLAVE), .MAX_INTENTOS(MAXI), .T_ABIERTO(TOPEN)
    ) dut (
        .clk(clk), .reset(reset),
        .llegado_vehiculo(llegado_vehiculo), .paso_vehiculo(paso_vehiculo), .boton_reset(boton_reset),
        .pin_valid(pin_valid), .clave_ingresada(clave_ingresada),
        .cargar_clave(cargar_clave), .clave_nueva(clave_nueva),
        .abriendo_compuerta(abriendo_compuerta), .cerrando_compuerta(cerrando_compuerta),
        .alarm_pin_incorrecto(alarm_pin_incorrecto), .alarm_timeout(alarm_timeout),
        .alarm_bloqueo(alarm_bloqueo), .intentos(intentos), .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        e_abr = 0; e_cer = 0; e_inc = 0; e_to = 0;
        if (reset) begin
            m_state = 0; m_att = 0; m_timer = 0; m_key = CLAVE;
        end else if (m_state == 0) begin
            if (cargar_clave) m_key = clave_nueva;
            if (llegado_vehiculo) begin m_state = 1; m_att = 0; end
        end else if (m_state == 1) begin
            if (pin_valid && clave_ingresada == m_key) begin
                m_state = 2; m_att = 0; m_timer = 0; e_abr = 1;
            end else if (pin_valid) begin
                m_att++; e_inc = 1;
                if (m_att == MAXI) m_state = 3;
            end
        end else if (m_state == 2) begin
            if (paso_vehiculo && llegado_vehiculo) m_state = 3;
            else if (paso_vehiculo) begin m_state = 0; e_cer = 1; end
            else if (m_timer == TOPEN - 1) begin m_state = 0; e_cer = 1; e_to = 1; end
            else m_timer++;
        end else begin
            if (boton_reset) begin m_state = 0; m_att = 0; end
        end
    endtask

    task automatic compare_all();
        check("estado",   32'(estado),               32'(m_state));
        check("intentos", 32'(intentos),             32'(m_att));
        check("abriendo", 32'(abriendo_compuerta),   32'(e_abr));
        check("cerrando", 32'(cerrando_compuerta),   32'(e_cer));
        check("pin_inc",  32'(alarm_pin_incorrecto), 32'(e_inc));
        check("timeout",  32'(alarm_timeout),        32'(e_to));
        check("bloqueo",  32'(alarm_bloqueo),        32'(m_state == 3));
    endtask

    // Inputs are held stable across the edge; the model and the DUT both see them at posedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        llegado_vehiculo = 0; paso_vehiculo = 0; boton_reset = 0;
        pin_valid = 0; cargar_clave = 0; clave_ingresada = '0; clave_nueva = '0;
    endtask

    task automatic present_pin(input logic [15:0] pin);
        pin_valid = 1; clave_ingresada = pin;
        cycle();
        pin_valid = 0;
    endtask

    initial begin
        int n;
        m_state = 0; m_att = 0; m_timer = 0; m_key = CLAVE;
        clear_inputs();
        reset = 1;
        cycle();
        cycle();
        check("rst_estado", 32'(estado), 0);
        check("rst_bloqueo", 32'(alarm_bloqueo), 0);
        reset = 0;

        // Normal entry with the initial key, then passage.
        llegado_vehiculo = 1; cycle(); llegado_vehiculo = 0;
        check("s1_estado1", 32'(estado), 1);
        present_pin(16'h1194);
        check("s1_estado2", 32'(estado), 2);
        check("s1_abr", 32'(abriendo_compuerta), 1);
        cycle();
        check("s1_abr_pulse", 32'(abriendo_compuerta), 0);
        paso_vehiculo = 1; cycle(); paso_vehiculo = 0;
        check("s1_cer", 32'(cerrando_compuerta), 1);
        check("s1_estado0", 32'(estado), 0);
        cycle();

        // Three wrong PINs lock the gate; operator releases it.
        llegado_vehiculo = 1; cycle(); llegado_vehiculo = 0;
        for (int i = 1; i <= 3; i++) begin
            present_pin(16'h0000);
            check("s2_intentos", 32'(intentos), 32'(i));
            check("s2_inc", 32'(alarm_pin_incorrecto), 1);
            cycle();
            check("s2_inc_pulse", 32'(alarm_pin_incorrecto), 0);
        end
        check("s2_estado3", 32'(estado), 3);
        check("s2_bloqueo", 32'(alarm_bloqueo), 1);
        pin_valid = 1; clave_ingresada = CLAVE; llegado_vehiculo = 1; cycle();
        clear_inputs();
        check("s2_ignored", 32'(estado), 3);
        boton_reset = 1; cycle(); boton_reset = 0;
        check("s2_release", 32'(estado), 0);
        check("s2_intentos0", 32'(intentos), 0);

        // Timeout after exactly TOPEN cycles open.
        llegado_vehiculo = 1; cycle(); llegado_vehiculo = 0;
        present_pin(CLAVE);
        n = (estado == 2) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (estado == 2) n++;
            else break;
        end
        check("s3_open_cycles", 32'(n), 32'(TOPEN));
        check("s3_cer", 32'(cerrando_compuerta), 1);
        check("s3_to", 32'(alarm_timeout), 1);
        check("s3_estado0", 32'(estado), 0);
        cycle();

        // Tailgating.
        llegado_vehiculo = 1; cycle(); llegado_vehiculo = 0;
        present_pin(CLAVE);
        paso_vehiculo = 1; llegado_vehiculo = 1; cycle();
        paso_vehiculo = 0; llegado_vehiculo = 0;
        check("s4_estado3", 32'(estado), 3);
        check("s4_no_cer", 32'(cerrando_compuerta), 0);
        boton_reset = 1; cycle(); boton_reset = 0;

        // Key reprogramming in IDLE; ignored while waiting for a PIN.
        cargar_clave = 1; clave_nueva = 16'hBEEF; cycle(); cargar_clave = 0;
        llegado_vehiculo = 1; cycle(); llegado_vehiculo = 0;
        present_pin(16'h1194);
        check("s5_old_rejected", 32'(alarm_pin_incorrecto), 1);
        present_pin(16'hBEEF);
        check("s5_new_accepted", 32'(abriendo_compuerta), 1);
        paso_vehiculo = 1; cycle(); paso_vehiculo = 0;
        llegado_vehiculo = 1; cycle(); llegado_vehiculo = 0;
        cargar_clave = 1; clave_nueva = 16'h1234; cycle(); cargar_clave = 0;
        present_pin(16'hBEEF);
        check("s5_key_kept", 32'(abriendo_compuerta), 1);
        paso_vehiculo = 1; cycle(); paso_vehiculo = 0;

        // Load and arrival together: the new key governs the very next PIN.
        cargar_clave = 1; clave_nueva = 16'hCAFE; llegado_vehiculo = 1; cycle();
        cargar_clave = 0; llegado_vehiculo = 0;
        present_pin(16'hCAFE);
        check("s6_same_cycle", 32'(abriendo_compuerta), 1);

        // Reset while open with timer at 3 restores the initial key.
        cycle(); cycle(); cycle();
        reset = 1; cycle(); reset = 0;
        check("s7_estado", 32'(estado), 0);
        check("s7_outputs", 32'({abriendo_compuerta, cerrando_compuerta, alarm_pin_incorrecto,
                                  alarm_timeout, alarm_bloqueo}), 0);
        cycle();
        check("s7_no_pulse", 32'(cerrando_compuerta), 0);
        llegado_vehiculo = 1; cycle(); llegado_vehiculo = 0;
        present_pin(16'h1194);
        check("s7_key_init", 32'(abriendo_compuerta), 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset            = ($urandom_range(199) == 0);
            llegado_vehiculo = ($urandom_range(3) == 0);
            paso_vehiculo    = ($urandom_range(4) == 0);
            boton_reset      = ($urandom_range(3) == 0);
            pin_valid        = ($urandom_range(2) == 0);
            clave_ingresada  = ($urandom_range(1) == 0) ? m_key : 16'($urandom);
            cargar_clave     = ($urandom_range(9) == 0);
            clave_nueva      = 16'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
